// File: rtl/mc_control_unit_p_if.sv
// Control bus between the multicycle controller and the datapath.
// The slave side is the controller: it consumes IR fields and the ALU overflow flag.
interface mc_control_unit_p_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Of;
  logic       PCWrite, PCWriteCond, BranchNe, MemWrite, IRWrite, MDRWrite, RegWrite;
  logic       LoadA, LoadB, ALUOutWrite, EPCWrite, MemToReg, ALUSrcA;
  logic [1:0] RegDst, ALUSrcB, PCSource, ExcCause;
  logic [2:0] IorD, ALUOp;
  logic       rst_out;

  modport slave (
    input  opcode, funct, Of,
    output PCWrite, PCWriteCond, BranchNe, MemWrite, IRWrite, MDRWrite, RegWrite,
           LoadA, LoadB, ALUOutWrite, EPCWrite, MemToReg, ALUSrcA,
           RegDst, ALUSrcB, PCSource, ExcCause, IorD, ALUOp, rst_out
  );

  modport master (
    output opcode, funct, Of,
    input  PCWrite, PCWriteCond, BranchNe, MemWrite, IRWrite, MDRWrite, RegWrite,
           LoadA, LoadB, ALUOutWrite, EPCWrite, MemToReg, ALUSrcA,
           RegDst, ALUSrcB, PCSource, ExcCause, IorD, ALUOp, rst_out
  );
endinterface

// File: rtl/mc_control_unit_p.sv
// Multicycle MIPS-subset controller with configurable memory wait and exceptions.
// Outputs are decoded from the registered state and wait counter.
module mc_control_unit_p #(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 3
) (
  input logic              clk,
  input logic              reset,
  mc_control_unit_p_if.slave bus
);
  if (2**CNT_W <= MEM_WAIT) begin : g_param_check
    $error("mc_control_unit_p: CNT_W too narrow for MEM_WAIT");
  end

  localparam logic [3:0] ST_RESET    = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_R_EX     = 4'd3;
  localparam logic [3:0] ST_R_WB     = 4'd4;
  localparam logic [3:0] ST_ADDI_EX  = 4'd5;
  localparam logic [3:0] ST_ADDI_WB  = 4'd6;
  localparam logic [3:0] ST_MEM_ADDR = 4'd7;
  localparam logic [3:0] ST_LW_RD    = 4'd8;
  localparam logic [3:0] ST_LW_WB    = 4'd9;
  localparam logic [3:0] ST_SW_WR    = 4'd10;
  localparam logic [3:0] ST_BRANCH   = 4'd11;
  localparam logic [3:0] ST_JUMP     = 4'd12;
  localparam logic [3:0] ST_EXC_OPC  = 4'd13;
  localparam logic [3:0] ST_EXC_OVF  = 4'd14;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT);

  logic [3:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             at_wait;
  logic             r_valid;

  assign at_wait = (cnt_reg == WAIT_LAST);
  assign r_valid = (bus.funct == 6'h20) || (bus.funct == 6'h22) || (bus.funct == 6'h24);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_RESET;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Only the two memory-wait states hold; every other state lasts one cycle.
  always_comb begin
    state_next = ST_FETCH;
    cnt_next   = '0;
    case (state_reg)
      ST_FETCH: begin
        if (at_wait) state_next = ST_DECODE;
        else begin
          state_next = ST_FETCH;
          cnt_next   = cnt_reg + 1'b1;
        end
      end
      ST_DECODE: begin
        case (bus.opcode)
          6'h00:        state_next = r_valid ? ST_R_EX : ST_EXC_OPC;
          6'h08:        state_next = ST_ADDI_EX;
          6'h23, 6'h2B: state_next = ST_MEM_ADDR;
          6'h04, 6'h05: state_next = ST_BRANCH;
          6'h02:        state_next = ST_JUMP;
          6'h3F:        state_next = ST_RESET;
          default:      state_next = ST_EXC_OPC;
        endcase
      end
      ST_R_EX:
        state_next = (bus.Of && ((bus.funct == 6'h20) || (bus.funct == 6'h22))) ? ST_EXC_OVF : ST_R_WB;
      ST_ADDI_EX:
        state_next = bus.Of ? ST_EXC_OVF : ST_ADDI_WB;
      ST_MEM_ADDR: begin
        if (bus.opcode == 6'h23)      state_next = ST_LW_RD;
        else if (bus.opcode == 6'h2B) state_next = ST_SW_WR;
        else                          state_next = ST_FETCH;
      end
      ST_LW_RD: begin
        if (at_wait) state_next = ST_LW_WB;
        else begin
          state_next = ST_LW_RD;
          cnt_next   = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // Asserting reset forces the reset output pattern at once so nothing in flight can write.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.BranchNe    = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MDRWrite    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.LoadA       = 1'b0;
    bus.LoadB       = 1'b0;
    bus.ALUOutWrite = 1'b0;
    bus.EPCWrite    = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegDst      = 2'b00;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.ExcCause    = 2'b00;
    bus.IorD        = 3'b000;
    bus.ALUOp       = 3'b000;
    bus.rst_out     = 1'b0;
    if (reset || state_reg == ST_RESET) begin
      bus.rst_out = 1'b1;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          bus.ALUSrcB = 2'b01;
          bus.ALUOp   = 3'b001;
          bus.PCWrite = at_wait;
          bus.IRWrite = at_wait;
        end
        ST_DECODE: begin
          bus.LoadA       = 1'b1;
          bus.LoadB       = 1'b1;
          bus.ALUSrcB     = 2'b11;
          bus.ALUOp       = 3'b001;
          bus.ALUOutWrite = 1'b1;
        end
        ST_R_EX: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOutWrite = 1'b1;
          case (bus.funct)
            6'h20:   bus.ALUOp = 3'b001;
            6'h22:   bus.ALUOp = 3'b010;
            6'h24:   bus.ALUOp = 3'b011;
            default: bus.ALUOp = 3'b000;
          endcase
        end
        ST_R_WB: begin
          bus.RegDst   = 2'b01;
          bus.RegWrite = 1'b1;
        end
        ST_ADDI_EX, ST_MEM_ADDR: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUSrcB     = 2'b10;
          bus.ALUOp       = 3'b001;
          bus.ALUOutWrite = 1'b1;
        end
        ST_ADDI_WB: bus.RegWrite = 1'b1;
        ST_LW_RD: begin
          bus.IorD     = 3'b001;
          bus.MDRWrite = at_wait;
        end
        ST_LW_WB: begin
          bus.MemToReg = 1'b1;
          bus.RegWrite = 1'b1;
        end
        ST_SW_WR: begin
          bus.IorD     = 3'b001;
          bus.MemWrite = 1'b1;
        end
        ST_BRANCH: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = 3'b010;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
          bus.BranchNe    = (bus.opcode == 6'h05);
        end
        ST_JUMP: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b10;
        end
        ST_EXC_OPC, ST_EXC_OVF: begin
          bus.ALUSrcB  = 2'b01;
          bus.ALUOp    = 3'b010;
          bus.EPCWrite = 1'b1;
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b11;
          bus.ExcCause = (state_reg == ST_EXC_OVF) ? 2'b01 : 2'b00;
        end
        default: bus.rst_out = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_control_unit_p.sv
// Bench for mc_control_unit_p: three instances (MEM_WAIT 2, 3, 0) checked cycle by
// cycle against per-instruction expected output traces.
module tb_mc_control_unit_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  typedef struct packed {
    logic       PCWrite, PCWriteCond, BranchNe, MemWrite, IRWrite, MDRWrite, RegWrite;
    logic       LoadA, LoadB, ALUOutWrite, EPCWrite, MemToReg, ALUSrcA;
    logic [1:0] RegDst, ALUSrcB, PCSource, ExcCause;
    logic [2:0] IorD, ALUOp;
    logic       rst_out;
  } ctl_t;

  ctl_t       obs  [3];
  logic [5:0] op_d [3];
  logic [5:0] fn_d [3];
  logic       of_d [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mc_control_unit_p_if bus ();
    assign bus.opcode = op_d[gi];
    assign bus.funct  = fn_d[gi];
    assign bus.Of     = of_d[gi];
    mc_control_unit_p #(.MEM_WAIT(gi == 0 ? 2 : (gi == 1 ? 3 : 0)), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .bus(bus)
    );
    assign obs[gi] = {bus.PCWrite, bus.PCWriteCond, bus.BranchNe, bus.MemWrite, bus.IRWrite,
                      bus.MDRWrite, bus.RegWrite, bus.LoadA, bus.LoadB, bus.ALUOutWrite,
                      bus.EPCWrite, bus.MemToReg, bus.ALUSrcA, bus.RegDst, bus.ALUSrcB,
                      bus.PCSource, bus.ExcCause, bus.IorD, bus.ALUOp, bus.rst_out};
  end

  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  ctl_t exp_q [$];

  function automatic int mw_of(input int sel);
    return (sel == 0) ? 2 : ((sel == 1) ? 3 : 0);
  endfunction

  task automatic check(input int sel, input ctl_t e, input string tag);
    checks++;
    assert (obs[sel] === e) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs[sel], e);
    end
  endtask

  task automatic push_exc(input logic [1:0] cause);
    ctl_t w = '0;
    w.ALUSrcB = 2'b01; w.ALUOp = 3'b010; w.EPCWrite = 1'b1;
    w.PCWrite = 1'b1;  w.PCSource = 2'b11; w.ExcCause = cause;
    exp_q.push_back(w);
  endtask

  // Expected output per cycle for one whole instruction, starting at the first fetch cycle.
  task automatic build(input int mw, input logic [5:0] op, input logic [5:0] fn, input logic of);
    ctl_t w;
    exp_q.delete();
    for (int i = 0; i <= mw; i++) begin
      w = '0; w.ALUSrcB = 2'b01; w.ALUOp = 3'b001;
      if (i == mw) begin w.PCWrite = 1'b1; w.IRWrite = 1'b1; end
      exp_q.push_back(w);
    end
    w = '0; w.LoadA = 1'b1; w.LoadB = 1'b1; w.ALUSrcB = 2'b11; w.ALUOp = 3'b001; w.ALUOutWrite = 1'b1;
    exp_q.push_back(w);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      w = '0; w.ALUSrcA = 1'b1; w.ALUOutWrite = 1'b1;
      w.ALUOp = (fn == 6'h20) ? 3'b001 : ((fn == 6'h22) ? 3'b010 : 3'b011);
      exp_q.push_back(w);
      if (of && fn != 6'h24) push_exc(2'b01);
      else begin w = '0; w.RegDst = 2'b01; w.RegWrite = 1'b1; exp_q.push_back(w); end
    end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
      w = '0; w.ALUSrcA = 1'b1; w.ALUSrcB = 2'b10; w.ALUOp = 3'b001; w.ALUOutWrite = 1'b1;
      exp_q.push_back(w);
      if (op == 6'h08) begin
        if (of) push_exc(2'b01);
        else begin w = '0; w.RegWrite = 1'b1; exp_q.push_back(w); end
      end else if (op == 6'h23) begin
        for (int i = 0; i <= mw; i++) begin
          w = '0; w.IorD = 3'b001; w.MDRWrite = (i == mw); exp_q.push_back(w);
        end
        w = '0; w.MemToReg = 1'b1; w.RegWrite = 1'b1; exp_q.push_back(w);
      end else begin
        w = '0; w.IorD = 3'b001; w.MemWrite = 1'b1; exp_q.push_back(w);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      w = '0; w.ALUSrcA = 1'b1; w.ALUOp = 3'b010; w.PCWriteCond = 1'b1;
      w.PCSource = 2'b01; w.BranchNe = (op == 6'h05);
      exp_q.push_back(w);
    end else if (op == 6'h02) begin
      w = '0; w.PCWrite = 1'b1; w.PCSource = 2'b10; exp_q.push_back(w);
    end else if (op == 6'h3F) begin
      w = '0; w.rst_out = 1'b1; exp_q.push_back(w);
    end else begin
      push_exc(2'b00);
    end
  endtask

  task automatic run_instr(input int sel, input logic [5:0] op, input logic [5:0] fn,
                           input logic of, input string tag);
    op_d[sel] = op; fn_d[sel] = fn; of_d[sel] = of;
    build(mw_of(sel), op, fn, of);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); #1;
      check(sel, exp_q[k], $sformatf("dut%0d %s op=%h fn=%h of=%0d c%0d", sel, tag, op, fn, of, k));
    end
  endtask

  task automatic do_reset();
    ctl_t w = '0;
    w.rst_out = 1'b1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) check(s, w, $sformatf("dut%0d reset c%0d", s, c));
    end
    reset = 1'b0;
  endtask

  task automatic run_random(input int sel, input int n);
    logic [5:0] op, fn;
    logic       of;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = 6'h00;
        2:       op = 6'h08;
        3:       op = 6'h23;
        4:       op = 6'h2B;
        5:       op = 6'h04;
        6:       op = 6'h05;
        7:       op = 6'h02;
        8:       op = 6'h3F;
        default: op = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 3))
        0:       fn = 6'h20;
        1:       fn = 6'h22;
        2:       fn = 6'h24;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      of = 1'($urandom_range(0, 1));
      run_instr(sel, op, fn, of, "rand");
    end
  endtask

  initial begin
    ctl_t rst_w;
    rst_w = '0;
    rst_w.rst_out = 1'b1;
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin op_d[s] = '0; fn_d[s] = '0; of_d[s] = 1'b0; end

    do_reset();
    run_instr(0, 6'h00, 6'h20, 1'b0, "add");
    run_instr(0, 6'h00, 6'h24, 1'b1, "and_of");
    run_instr(0, 6'h00, 6'h22, 1'b1, "sub_ovf");
    run_instr(0, 6'h08, 6'h00, 1'b1, "addi_ovf");
    run_instr(0, 6'h08, 6'h00, 1'b0, "addi");
    run_instr(0, 6'h2B, 6'h00, 1'b0, "sw");
    run_instr(0, 6'h05, 6'h00, 1'b0, "bne");
    run_instr(0, 6'h04, 6'h00, 1'b1, "beq");
    run_instr(0, 6'h02, 6'h00, 1'b0, "j");
    run_instr(0, 6'h11, 6'h00, 1'b0, "bad_op");
    run_instr(0, 6'h00, 6'h21, 1'b0, "bad_funct");
    run_instr(0, 6'h3F, 6'h00, 1'b0, "op3f");
    run_instr(0, 6'h23, 6'h00, 1'b0, "lw_after_3f");
    run_random(0, 30);

    do_reset();
    run_instr(1, 6'h23, 6'h00, 1'b1, "lw");
    // Abort a load in its first read cycle and make sure it never writes the MDR.
    op_d[1] = 6'h23; fn_d[1] = 6'h00; of_d[1] = 1'b0;
    build(3, 6'h23, 6'h00, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      check(1, exp_q[k], $sformatf("dut1 lw_abort c%0d", k));
    end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check(1, rst_w, $sformatf("dut1 lw_abort reset c%0d", c));
    end
    reset = 1'b0;
    run_instr(1, 6'h00, 6'h20, 1'b0, "add_after_abort");
    run_random(1, 30);

    do_reset();
    run_instr(2, 6'h23, 6'h00, 1'b0, "lw_w0");
    run_instr(2, 6'h00, 6'h22, 1'b0, "sub_w0");
    run_random(2, 30);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
